// File: rtl/output_writeback_arbiter.sv
// Round-robin RMW accumulation of per-column result FIFOs into one output RAM.
// Define OUTPUT_ARB_PROXY_EN to add the weight-proxy requesters.
module output_writeback_arbiter #(
  parameter int WORD_SIZE  = 16,
  parameter int FIFO_DEPTH = 4,
  parameter int ROWS       = 4,
  parameter int COLS       = 4,
  parameter int ADDR_WIDTH = $clog2(ROWS*COLS)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      clear_start,
  input  logic [COLS-1:0]           mm_valid,
  input  logic [COLS*WORD_SIZE-1:0] mm_data,
  input  logic [COLS-1:0]           px_valid,
  input  logic [COLS*WORD_SIZE-1:0] px_data,
  output logic [ADDR_WIDTH-1:0]     ram_addr,
  output logic                      ram_re,
  output logic                      ram_we,
  output logic [WORD_SIZE-1:0]      ram_wdata,
  input  logic [WORD_SIZE-1:0]      ram_rdata,
  output logic                      busy,
  output logic [2*COLS-1:0]         overflow
);

`ifdef OUTPUT_ARB_PROXY_EN
  localparam int NR = 2*COLS;
`else
  localparam int NR = COLS;
`endif
  localparam int N  = ROWS*COLS;
  localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int IW = (NR > 1) ? $clog2(NR) : 1;
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {IDLE, RD, WR, CLEAR} state_t;

  state_t state, state_n;
  logic re_n, we_n, acc_q, acc_n;
  logic clr_pend_q, clr_n, clr_done;
  logic [ADDR_WIDTH-1:0] addr_n;
  logic [WORD_SIZE-1:0] opnd_q, opnd_n;
  logic [IW-1:0] rr_q, rr_n, gidx, tidx;
  logic gfound;
  logic [RW-1:0] head_row;
  int t, col;

  logic [NR-1:0] req_valid;
  logic [WORD_SIZE-1:0] req_data [NR];

  logic [RW-1:0] f_row [NR][FIFO_DEPTH];
  logic [WORD_SIZE-1:0] f_dat [NR][FIFO_DEPTH];
  logic [PW-1:0] f_wp [NR];
  logic [PW-1:0] f_rp [NR];
  logic [CW-1:0] f_cnt [NR];
  logic [RW-1:0] row_cnt [NR];
  logic [NR-1:0] ovf_q;
  logic [NR-1:0] nonempty, full, push, pop, drop;

  always_comb begin
    req_valid = '0;
    for (int c = 0; c < COLS; c++) begin
      req_valid[c] = mm_valid[c];
      req_data[c]  = mm_data[c*WORD_SIZE +: WORD_SIZE];
`ifdef OUTPUT_ARB_PROXY_EN
      req_valid[COLS+c] = px_valid[c];
      req_data[COLS+c]  = px_data[c*WORD_SIZE +: WORD_SIZE];
`endif
    end
  end

`ifdef OUTPUT_ARB_PROXY_EN
  assign overflow = ovf_q;
`else
  logic unused_px;
  assign unused_px = ^{px_valid, px_data};
  assign overflow  = {{COLS{1'b0}}, ovf_q};
`endif

  always_comb begin
    nonempty = '0;
    full     = '0;
    for (int i = 0; i < NR; i++) begin
      nonempty[i] = (f_cnt[i] != '0);
      full[i]     = (f_cnt[i] == CW'(FIFO_DEPTH));
    end
  end

  // a full FIFO still accepts a push when it is popped the same cycle
  always_comb begin
    push = '0;
    drop = '0;
    for (int i = 0; i < NR; i++) begin
      push[i] = req_valid[i] & (~full[i] | pop[i]);
      drop[i] = req_valid[i] & full[i] & ~pop[i];
    end
  end

  always_comb begin
    state_n  = state;
    re_n     = 1'b0;
    we_n     = 1'b0;
    acc_n    = 1'b0;
    addr_n   = ram_addr;
    opnd_n   = opnd_q;
    rr_n     = rr_q;
    clr_n    = clr_pend_q | clear_start;
    clr_done = 1'b0;
    pop      = '0;
    gfound   = 1'b0;
    gidx     = '0;
    tidx     = '0;
    t        = 0;
    for (int k = 0; k < NR; k++) begin
      t = int'(rr_q) + k;
      if (t >= NR) t = t - NR;
      tidx = IW'(t);
      if (!gfound && nonempty[tidx]) begin
        gfound = 1'b1;
        gidx   = tidx;
      end
    end
    col      = (int'(gidx) >= COLS) ? int'(gidx) - COLS : int'(gidx);
    head_row = f_row[gidx][f_rp[gidx]];
    unique case (state)
      IDLE, WR: begin
        if (clr_pend_q) begin
          state_n = CLEAR;
          we_n    = 1'b1;
          addr_n  = '0;
          clr_n   = 1'b0;
        end else if (gfound) begin
          state_n   = RD;
          re_n      = 1'b1;
          addr_n    = ADDR_WIDTH'(int'(head_row)*COLS + col);
          opnd_n    = f_dat[gidx][f_rp[gidx]];
          pop[gidx] = 1'b1;
          rr_n      = (int'(gidx) == NR-1) ? '0 : gidx + 1'b1;
        end else begin
          state_n = IDLE;
        end
      end
      RD: begin
        state_n = WR;
        we_n    = 1'b1;
        acc_n   = 1'b1;
      end
      CLEAR: begin
        if (ram_addr == ADDR_WIDTH'(N-1)) begin
          state_n  = IDLE;
          clr_done = 1'b1;
          addr_n   = '0;
        end else begin
          we_n   = 1'b1;
          addr_n = ram_addr + 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      ram_re     <= 1'b0;
      ram_we     <= 1'b0;
      acc_q      <= 1'b0;
      ram_addr   <= '0;
      opnd_q     <= '0;
      rr_q       <= '0;
      clr_pend_q <= 1'b0;
    end else begin
      state      <= state_n;
      ram_re     <= re_n;
      ram_we     <= we_n;
      acc_q      <= acc_n;
      ram_addr   <= addr_n;
      opnd_q     <= opnd_n;
      rr_q       <= rr_n;
      clr_pend_q <= clr_n;
    end
  end

  // read data arrives in WR, so the sum is formed on the way out
  assign ram_wdata = acc_q ? ram_rdata + opnd_q : '0;
  assign busy      = (state != IDLE) | (|nonempty) | clr_pend_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NR; i++) begin
        f_wp[i]    <= '0;
        f_rp[i]    <= '0;
        f_cnt[i]   <= '0;
        row_cnt[i] <= '0;
      end
      ovf_q <= '0;
    end else begin
      for (int i = 0; i < NR; i++) begin
        if (push[i]) f_wp[i] <= f_wp[i] + 1'b1;
        if (pop[i]) f_rp[i] <= f_rp[i] + 1'b1;
        if (push[i] && !pop[i]) f_cnt[i] <= f_cnt[i] + 1'b1;
        else if (!push[i] && pop[i]) f_cnt[i] <= f_cnt[i] - 1'b1;
        if (clr_done) begin
          row_cnt[i] <= '0;
          ovf_q[i]   <= 1'b0;
        end else begin
          if (req_valid[i])
            row_cnt[i] <= (row_cnt[i] == RW'(ROWS-1)) ? '0 : row_cnt[i] + 1'b1;
          if (drop[i]) ovf_q[i] <= 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < NR; i++) begin
      if (push[i]) begin
        f_row[i][f_wp[i]] <= row_cnt[i];
        f_dat[i][f_wp[i]] <= req_data[i];
      end
    end
  end

endmodule

// File: doc/output_writeback_arbiter.md
# output_writeback_arbiter

- Shares a single-port output-matrix RAM between the systolic array's per-column result stream and the weight-proxy per-column result stream.
- Buffers each requester in a small FIFO and tags every entry with its output row.
- Arbitrates round-robin across requesters and performs read-modify-write accumulation into the RAM.
- Sits between `systolic_matmul_fsm` / proxy outputs and the output-matrix RAM, replacing per-column clocked writes with a single-clock scheduled port.

## Interface
Parameters (`ROWS`, `COLS` come from `header_ws.vh`; ADDR_WIDTH = $clog2(`ROWS*`COLS)):
- WORD_SIZE, 16, data width
- FIFO_DEPTH, 4, entries per requester FIFO (power of 2, ≥2)

Ports:
- clk  in  1  sole clock, rising edge
- rst  in  1  asynchronous, active-high reset
- clear_start  in  1  pulse: zero the whole RAM
- mm_valid  in  COLS  one-cycle pulse per new matmul result, per column
- mm_data  in  COLS*WORD_SIZE  column c at [c*WORD_SIZE +: WORD_SIZE]
- px_valid  in  COLS  one-cycle pulse per new proxy result, per column
- px_data  in  COLS*WORD_SIZE  same packing as mm_data
- ram_addr  out  ADDR_WIDTH  row*COLS + col
- ram_re  out  1  read strobe; ram_rdata valid the next cycle
- ram_we  out  1  write strobe
- ram_wdata  out  WORD_SIZE  write data
- ram_rdata  in  WORD_SIZE  read data, 1-cycle latency
- busy  out  1  FSM not IDLE, any FIFO non-empty, or clear pending
- overflow  out  2*COLS  sticky per-requester drop flags; [c] = matmul, [COLS+c] = proxy

## Operation
- Requesters: index 0..COLS-1 = matmul columns, COLS..2*COLS-1 = proxy columns.
- Each requester has a row counter (0..ROWS-1, wraps to 0) and a FIFO of {row, data}.
- A valid pulse pushes {row counter, data} and increments the row counter.
- Push when full and not popping in the same cycle: entry dropped, overflow bit set, row counter still advances.
- Push and pop in the same cycle on a full FIFO is accepted.
- FSM states:
  - IDLE: a pending clear wins and goes to CLEAR. Otherwise, if any FIFO is non-empty, grant round-robin, pop, and go to RD.
  - RD: ram_re=1, ram_addr = row*COLS+col of the granted entry. Next state is WR.
  - WR: ram_we=1, same address, ram_wdata = ram_rdata + data, truncated mod 2^WORD_SIZE. From WR, a pending clear goes to CLEAR; else a non-empty FIFO grants, pops and goes to RD; else IDLE.
  - CLEAR: ram_we=1, ram_wdata=0, ram_addr counts 0..ROWS*COLS-1, one address per cycle. After the last address: all row counters and overflow bits are zeroed, then IDLE.
- Round-robin pointer starts at 0. After a grant to index i, the search starts at i+1 (mod 2*COLS).
- clear_start in any state sets clear pending; clear pending is cleared on entering CLEAR.
- FIFOs keep accepting pushes during CLEAR. Their stored row tags are kept.
- No RAW hazard: a WR updates the RAM at its cycle end, before the next RD.

## Timing
- Reset values: state IDLE, FIFOs empty, row counters 0, RR pointer 0, clear pending 0.
- Output reset values: ram_re/ram_we/ram_addr/ram_wdata 0, overflow 0, busy 0.
- ram_addr, ram_re, ram_we and ram_wdata are driven from flops. ram_wdata in WR may add the registered operand to ram_rdata combinationally.
- Latency with the FSM in IDLE: valid in cycle t → push at end of t → grant in t+1 → RD in t+2 → WR in t+3.
- Sustained throughput: one accumulate per 2 cycles.
- CLEAR lasts exactly ROWS*COLS cycles.
- rst assertion mid-operation immediately forces all outputs to reset values. An interrupted RMW is abandoned.

## Configuration
- OUTPUT_ARB_PROXY_EN defined: proxy requesters are present, as described.
- Undefined:
  - px_valid and px_data are ignored.
  - Proxy FIFOs and counters are not built.
  - Round-robin is over COLS requesters.
  - overflow[2*COLS-1:COLS] is tied to 0.

## Test plan
Bench settings: ROWS=COLS=4, WORD_SIZE=16, FIFO_DEPTH=4.
- RAM[2]=0x0003; mm_valid[2] pulse with data 0x0005 at t → RD addr 2 at t+2; WR addr 2, wdata 0x0008 at t+3.
- Five mm_valid[2] pulses, 1 each, ≥2 cycles apart, RAM zeroed → writes go to addr 2, 6, 10, 14, then 2 again (ends at 2).
- mm_valid[0] (data 1) and px_valid[0] (data 2) in the same cycle, RAM[0]=0 → matmul granted first. WRs occur at t+3 (0x0001) and t+5 (0x0003).
- RAM[5]=0xFFFF, mm_valid[1] pulse with data 0x0002 on row 1 → WR addr 5, wdata 0x0001.
- clear_start, then five mm_valid[1] pulses during CLEAR:
  - 16 zero-writes occur.
  - overflow[1]=1 until CLEAR ends, then 0.
  - Four queued entries are then accumulated.
  - busy stays 1 until the last WR.
- rst asserted during WR → ram_we, ram_re, busy and overflow go to 0 in the same cycle. After release, the FSM is IDLE and a new pulse maps to row 0.
